// File: rtl/jzjpcc_mem_arbiter_if.sv
// Fetch/load-store/RAM signal bundle for the shared single-port SRAM arbiter.
// slave = arbiter side, master = requesters plus RAM array side.
interface jzjpcc_mem_arbiter_if #(
  parameter int RAM_A_WIDTH = 12
);
  // fetch port
  logic                   fetchReq;
  logic [RAM_A_WIDTH-1:0] fetchAddr;
  logic                   fetchFlush;
  logic                   fetchGnt;
  logic                   fetchValid;
  logic [31:0]            fetchData;
  // load/store port
  logic                   dataReq;
  logic                   dataWe;
  logic [RAM_A_WIDTH-1:0] dataAddr;
  logic [31:0]            dataWdata;
  logic [3:0]             dataByteMask;
  logic                   dataGnt;
  logic                   dataValid;
  logic [31:0]            dataRdata;
  // RAM array
  logic [RAM_A_WIDTH-1:0] ramAddr;
  logic [31:0]            ramWdata;
  logic [3:0]             ramByteMask;
  logic                   ramWe;
  logic [31:0]            ramRdata;
  // status
  logic [15:0]            fetchStallCount;

  modport slave (
    input  fetchReq, fetchAddr, fetchFlush,
    input  dataReq, dataWe, dataAddr, dataWdata, dataByteMask,
    input  ramRdata,
    output fetchGnt, fetchValid, fetchData,
    output dataGnt, dataValid, dataRdata,
    output ramAddr, ramWdata, ramByteMask, ramWe,
    output fetchStallCount
  );

  modport master (
    output fetchReq, fetchAddr, fetchFlush,
    output dataReq, dataWe, dataAddr, dataWdata, dataByteMask,
    output ramRdata,
    input  fetchGnt, fetchValid, fetchData,
    input  dataGnt, dataValid, dataRdata,
    input  ramAddr, ramWdata, ramByteMask, ramWe,
    input  fetchStallCount
  );
endinterface

// File: rtl/jzjpcc_mem_arbiter.sv
// Shares one single-port SRAM between fetch and load/store; data wins unless fetch
// has been denied MAX_FETCH_WAIT cycles in a row. Read data returns one cycle after grant.
module jzjpcc_mem_arbiter #(
  parameter int RAM_A_WIDTH    = 12,
  parameter int MAX_FETCH_WAIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  jzjpcc_mem_arbiter_if.slave   bus
);

  localparam logic [1:0] OWN_NONE     = 2'd0;
  localparam logic [1:0] OWN_FETCH_RD = 2'd1;
  localparam logic [1:0] OWN_DATA_RD  = 2'd2;

  localparam logic [3:0]  STARVE_MAX = 4'(MAX_FETCH_WAIT);
  localparam logic [15:0] STALL_MAX  = 16'hFFFF;

  logic [1:0]  owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic                   force_fetch;
  logic                   fetch_eligible;
  logic                   fetch_gnt;
  logic                   data_gnt;
  logic [RAM_A_WIDTH-1:0] ram_addr;

  // Grant decision uses only requests and registered state, never ramRdata.
  always_comb begin
    force_fetch    = (starve_q == STARVE_MAX);
    fetch_eligible = bus.fetchReq & ~bus.fetchFlush;
    fetch_gnt      = 1'b0;
    data_gnt       = 1'b0;
    if (force_fetch && fetch_eligible) begin
      fetch_gnt = 1'b1;
    end else if (bus.dataReq) begin
      data_gnt = 1'b1;
    end else begin
      fetch_gnt = fetch_eligible;
    end
  end

  always_comb begin
    ram_addr = data_gnt ? bus.dataAddr : bus.fetchAddr;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (fetch_gnt) begin
      owner_d = OWN_FETCH_RD;
    end else if (data_gnt && !bus.dataWe) begin
      owner_d = OWN_DATA_RD;
    end
  end

  // Flush cycles clear starvation: the fetch address is about to change anyway.
  always_comb begin
    starve_d = starve_q;
    if (fetch_gnt || !bus.fetchReq || bus.fetchFlush) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.fetchReq && !fetch_gnt && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // RAM data arrives in the owner's valid cycle; the other port keeps its last word.
  always_comb begin
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    if (owner_q == OWN_FETCH_RD) begin
      fetch_data_d = bus.ramRdata;
    end
    if (owner_q == OWN_DATA_RD) begin
      data_rdata_d = bus.ramRdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_NONE;
      starve_q     <= 4'd0;
      stall_cnt_q  <= 16'd0;
      fetch_data_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      stall_cnt_q  <= stall_cnt_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    bus.fetchGnt        = fetch_gnt;
    bus.dataGnt         = data_gnt;
    bus.fetchValid      = (owner_q == OWN_FETCH_RD);
    bus.dataValid       = (owner_q == OWN_DATA_RD);
    bus.fetchData       = fetch_data_d;
    bus.dataRdata       = data_rdata_d;
    bus.ramAddr         = ram_addr;
    bus.ramWdata        = bus.dataWdata;
    bus.ramWe           = data_gnt & bus.dataWe;
    bus.ramByteMask     = (data_gnt && bus.dataWe) ? bus.dataByteMask : 4'b0000;
    bus.fetchStallCount = stall_cnt_q;
  end

endmodule

// File: doc/jzjpcc_mem_arbiter.md
Name: jzjpcc_mem_arbiter

Overview:
- Shares the single-port synchronous SRAM of the memory backend between the fetch stage's instruction port and the execute stage's load/store port.
- Data accesses win by default. A saturating starvation counter forces a fetch grant after MAX_FETCH_WAIT consecutive denied cycles.
- Returns read data one cycle after grant, routed to the requester that owns the in-flight read.
- Sits between fetch/execute and the RAM array; it replaces the fixed dual-port path.

Parameters:
- RAM_A_WIDTH, 12, RAM word-address width (2^RAM_A_WIDTH words).
- MAX_FETCH_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- fetchReq  in  1  fetch requests a word read.
- fetchAddr  in  RAM_A_WIDTH  fetch word address.
- fetchFlush  in  1  control transfer in progress; blocks fetch grant this cycle.
- fetchGnt  out  1  combinational; the fetch read is issued to the RAM this cycle.
- fetchValid  out  1  registered; fetchData is valid.
- fetchData  out  32  read data for fetch.
- dataReq  in  1  load/store request.
- dataWe  in  1  1 = store, 0 = load.
- dataAddr  in  RAM_A_WIDTH  data word address.
- dataWdata  in  32  store data.
- dataByteMask  in  4  store byte enables.
- dataGnt  out  1  combinational; the data access is issued this cycle.
- dataValid  out  1  registered; dataRdata is valid (loads only).
- dataRdata  out  32  load data.
- ramAddr  out  RAM_A_WIDTH  combinational mux to the RAM.
- ramWdata  out  32  equals dataWdata.
- ramByteMask  out  4  equals dataByteMask when the store is granted, else 0.
- ramWe  out  1  dataGnt & dataWe.
- ramRdata  in  32  RAM read data, one cycle after address.
- fetchStallCount  out  16  saturating count of cycles with fetchReq & !fetchGnt.

Behaviour:
- Reset (reset=0, async): fetchValid=0, dataValid=0, fetchData=0, dataRdata=0, owner=NONE, starvation counter=0, fetchStallCount=0. Any in-flight read is discarded; no valid is produced after reset releases.
- Requesters hold their request and address stable until granted. The arbiter never grants to a deasserted request.
- Grant logic (combinational, per cycle):
  - forceFetch = (starve == MAX_FETCH_WAIT).
  - fetchEligible = fetchReq & !fetchFlush.
  - If forceFetch & fetchEligible: fetchGnt=1, dataGnt=0.
  - Else if dataReq: dataGnt=1.
  - Else fetchGnt = fetchEligible.
  - At most one grant per cycle.
- ramAddr = dataAddr when dataGnt, else fetchAddr (fetchAddr also when idle). ramWe=0 unless a store is granted.
- Owner FSM (registered), states:
  - NONE: no read in flight.
  - FETCH_RD: fetch read granted last cycle.
  - DATA_RD: load granted last cycle.
  - Next state: FETCH_RD if fetchGnt; DATA_RD if dataGnt & !dataWe; else NONE. A granted store yields NONE.
- Read latency 1: a grant in cycle N gives valid=1 in N+1 to the owner only, with data = ramRdata registered through the owner mux. The non-owner's data output holds its previous value; its valid is 0. Valids are single-cycle pulses.
- Stores complete at grant; no dataValid pulse.
- Back-to-back grants are allowed every cycle, so full throughput is one access per cycle.
- Starvation counter (4 bits):
  - cleared when fetchGnt, !fetchReq, or fetchFlush;
  - otherwise incremented on a fetchReq & !fetchGnt cycle;
  - saturates at MAX_FETCH_WAIT.
- A fetchFlush cycle does not count as starvation.
- Simultaneous fetchFlush & forced fetch: fetch is not granted, the counter clears, and data may be granted.
- fetchStallCount: increments on each fetchReq & !fetchGnt cycle (including flush cycles) and saturates at 16'hFFFF.
- No combinational path from ramRdata to any grant signal.

Test Plan:
- Fetch only: fetchReq=1, fetchAddr=0x010, RAM word 0x010 = 0x00000013 for 3 cycles -> fetchGnt=1 each cycle; fetchValid=1 from cycle 1 with fetchData=0x00000013; dataValid=0.
- Contention, MAX_FETCH_WAIT=3, both requests held for 8 cycles -> dataGnt on cycles 0,1,2; fetchGnt on cycle 3; pattern repeats; fetchStallCount=6 after cycle 7.
- Load then store: load at 0x020 (contents 0xDEADBEEF) in cycle 0, then store 0xCAFEF00D with mask 4'b0011 to 0x020 in cycle 1 -> dataValid=1 with 0xDEADBEEF in cycle 1; ramWe=1 and ramByteMask=0011 in cycle 1; no dataValid in cycle 2.
- Flush: fetchReq=1 and fetchFlush=1 on the cycle starve would reach 3 -> fetchGnt=0, starve=0, dataGnt=1 if dataReq; no fetchValid next cycle.
- Async reset: assert reset=0 mid-cycle after a fetch grant -> fetchValid=0 immediately and stays 0 after release; counters read 0.
- Stall saturation: force 70000 denied fetch cycles -> fetchStallCount holds at 0xFFFF.
